// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: prioritised stall vector, held branch redirect, stall watchdog.
// Optional per-cause stall counters are built when STALL_PERF_EN is defined.
module pipe_stall_ctrl #(
   parameter int unsigned STALL_LIMIT = 1024,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_if,
   input  logic             stallreq_id,
   input  logic             stallreq_ex,
   input  logic             stallreq_mem,
   input  logic             branch_i,
   input  logic [31:0]      branch_target_i,
   output logic [5:0]       stall,
   output logic             flush,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             stall_timeout,
`ifdef STALL_PERF_EN
   input  logic [2:0]       perf_sel,
   output logic [CNT_W-1:0] perf_data,
`endif
   output logic             dbg_state_o
);

   localparam int unsigned WD_W = $clog2(STALL_LIMIT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_LIMIT);

   // Handshake: redirect_valid is a single-cycle strobe; the PC stage accepts it
   // exactly when stall[0]=0, so no ready signal is needed.
   typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [31:0]     pend_pc_q, pend_pc_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            timeout_q, timeout_d;

   assign dbg_state_o   = state_q;
   assign stall_timeout = timeout_q;

   always_comb begin
      stall = 6'b000000;
      if (stallreq_mem)     stall = 6'b011111;
      else if (stallreq_ex) stall = 6'b001111;
      else if (stallreq_id) stall = 6'b000111;
      else if (stallreq_if) stall = 6'b000011;
   end

   always_comb begin
      state_d        = state_q;
      pend_pc_d      = pend_pc_q;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      if (!rst) begin
         case (state_q)
            ST_IDLE: begin
               if (branch_i) begin
                  flush = 1'b1;
                  if (!stall[0]) begin
                     redirect_valid = 1'b1;
                     redirect_pc    = branch_target_i;
                  end else begin
                     pend_pc_d = branch_target_i;
                     state_d   = ST_PEND;
                  end
               end
            end
            ST_PEND: begin
               // Keep killing refilled slots; a newer branch replaces the held target.
               flush = 1'b1;
               if (branch_i) pend_pc_d = branch_target_i;
               if (!stall[0]) begin
                  redirect_valid = 1'b1;
                  redirect_pc    = branch_i ? branch_target_i : pend_pc_q;
                  state_d        = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      wd_d      = wd_q;
      timeout_d = timeout_q;
      if (!stall[0])          wd_d = '0;
      else if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
      if (stall[0] && wd_d == WD_MAX) timeout_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pend_pc_q <= 32'h0;
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_pc_q <= pend_pc_d;
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end

`ifdef STALL_PERF_EN
   logic [4:0]       cause;
   logic [CNT_W-1:0] perf_q [5];

   // Only the winning priority source is charged for a stalled cycle.
   assign cause = {flush,
                   stallreq_if & ~stallreq_id & ~stallreq_ex & ~stallreq_mem,
                   stallreq_id & ~stallreq_ex & ~stallreq_mem,
                   stallreq_ex & ~stallreq_mem,
                   stallreq_mem};

   always_ff @(posedge clk) begin
      for (int i = 0; i < 5; i++) begin
         if (rst)           perf_q[i] <= '0;
         else if (cause[i]) perf_q[i] <= perf_q[i] + 1'b1;
      end
   end

   always_comb begin
      perf_data = '0;
      case (perf_sel)
         3'd0:    perf_data = perf_q[0];
         3'd1:    perf_data = perf_q[1];
         3'd2:    perf_data = perf_q[2];
         3'd3:    perf_data = perf_q[3];
         3'd4:    perf_data = perf_q[4];
         default: perf_data = '0;
      endcase
   end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (STALL_LIMIT=8); perf checks run when STALL_PERF_EN is defined.
module tb_pipe_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
   logic        branch_i;
   logic [31:0] branch_target_i;
   logic [5:0]  stall;
   logic        flush, redirect_valid, stall_timeout, dbg_state_o;
   logic [31:0] redirect_pc;
`ifdef STALL_PERF_EN
   logic [2:0]  perf_sel;
   logic [31:0] perf_data;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(.STALL_LIMIT(8), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
      .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
      .branch_i(branch_i), .branch_target_i(branch_target_i),
      .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .stall_timeout(stall_timeout),
`ifdef STALL_PERF_EN
      .perf_sel(perf_sel), .perf_data(perf_data),
`endif
      .dbg_state_o(dbg_state_o)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [3:0] r); // {mem, ex, id, if}
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = r;
   endtask

   task automatic do_reset();
      rst = 1'b1; branch_i = 1'b0; branch_target_i = 32'h0; set_req(4'b0000);
      step(); step();
      rst = 1'b0;
      #1;
   endtask

   // Expect flush / redirect_valid / redirect_pc together.
   task automatic chk_redir(input string tag, input logic f, input logic v, input logic [31:0] pc);
      n_cmp++;
      if (flush !== f || redirect_valid !== v || redirect_pc !== pc) begin
         n_err++;
         $display("FAIL %s: got flush=%b rv=%b pc=%h, want flush=%b rv=%b pc=%h",
                  tag, flush, redirect_valid, redirect_pc, f, v, pc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; branch_i = 1'b1; branch_target_i = 32'hDEAD_0000; set_req(4'b0001);
      step(); step();
      n_cmp++;
      if (stall !== 6'b000011) begin
         n_err++; $display("FAIL reset_stall: got %b want 000011", stall);
      end
      chk_redir("reset_redir", 1'b0, 1'b0, 32'h0);
      rst = 1'b0; branch_i = 1'b0; set_req(4'b0000);
      #1;
      n_cmp++;
      if (stall_timeout !== 1'b0 || dbg_state_o !== 1'b0 || stall !== 6'b0) begin
         n_err++;
         $display("FAIL reset_state: got to=%b st=%b stall=%b want 0 0 000000",
                  stall_timeout, dbg_state_o, stall);
      end
   endtask

   task automatic test_priority();
      logic [3:0] req_t [10] = '{4'b0000, 4'b0001, 4'b0011, 4'b1011, 4'b0100,
                                 4'b0110, 4'b1111, 4'b1000, 4'b0010, 4'b0101};
      logic [5:0] exp_t [10] = '{6'h00, 6'h03, 6'h07, 6'h1F, 6'h0F,
                                 6'h0F, 6'h1F, 6'h1F, 6'h07, 6'h0F};
      for (int i = 0; i < 10; i++) begin
         set_req(req_t[i]);
         #1;
         n_cmp++;
         if (stall !== exp_t[i]) begin
            n_err++;
            $display("FAIL priority[%0d] req=%b: got %b want %b", i, req_t[i], stall, exp_t[i]);
         end
      end
      set_req(4'b0000);
   endtask

   task automatic test_branch_idle();
      do_reset();
      branch_i = 1'b1; branch_target_i = 32'h0000_0100;
      #1;
      chk_redir("idle_branch", 1'b1, 1'b1, 32'h100);
      step();
      branch_i = 1'b0;
      #1;
      chk_redir("idle_after", 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_branch_pend();
      do_reset();
      set_req(4'b0001); branch_i = 1'b1; branch_target_i = 32'h0000_0200;
      #1;
      chk_redir("pend_c1", 1'b1, 1'b0, 32'h0);
      step();
      branch_i = 1'b0;
      #1;
      n_cmp++;
      if (dbg_state_o !== 1'b1) begin
         n_err++; $display("FAIL pend_state: got %b want 1", dbg_state_o);
      end
      chk_redir("pend_c2", 1'b1, 1'b0, 32'h0);
      step();
      chk_redir("pend_c3", 1'b1, 1'b0, 32'h0);
      step();
      set_req(4'b0000);
      #1;
      chk_redir("pend_release", 1'b1, 1'b1, 32'h200);
      step();
      chk_redir("pend_done", 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_req(4'b0100); branch_i = 1'b1; branch_target_i = 32'h0000_0200;
      step();
      branch_target_i = 32'h0000_0300;
      #1;
      chk_redir("b2b_second", 1'b1, 1'b0, 32'h0);
      step();
      branch_i = 1'b0;
      #1;
      chk_redir("b2b_hold", 1'b1, 1'b0, 32'h0);
      step();
      set_req(4'b0000);
      #1;
      chk_redir("b2b_release", 1'b1, 1'b1, 32'h300);
      step();
      chk_redir("b2b_single", 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_rst_pend();
      do_reset();
      set_req(4'b1000); branch_i = 1'b1; branch_target_i = 32'h0000_0400;
      step();
      branch_i = 1'b0; rst = 1'b1;
      #1;
      chk_redir("rstpend_during", 1'b0, 1'b0, 32'h0);
      step();
      rst = 1'b0; set_req(4'b0000);
      #1;
      chk_redir("rstpend_after", 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_watchdog();
      do_reset();
      set_req(4'b1000);
      for (int i = 1; i <= 8; i++) begin
         step();
         n_cmp++;
         if (stall_timeout !== (i == 8)) begin
            n_err++;
            $display("FAIL wd_edge%0d: got %b want %b", i, stall_timeout, (i == 8));
         end
      end
      set_req(4'b0000);
      step(); step();
      n_cmp++;
      if (stall_timeout !== 1'b1) begin
         n_err++; $display("FAIL wd_sticky: got %b want 1", stall_timeout);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      n_cmp++;
      if (stall_timeout !== 1'b0) begin
         n_err++; $display("FAIL wd_reset: got %b want 0", stall_timeout);
      end
      // Seven stalled cycles, a gap, seven more: the gap must restart the count.
      set_req(4'b0001);
      for (int i = 0; i < 7; i++) step();
      set_req(4'b0000);
      step();
      set_req(4'b0001);
      for (int i = 0; i < 7; i++) step();
      set_req(4'b0000);
      #1;
      n_cmp++;
      if (stall_timeout !== 1'b0) begin
         n_err++; $display("FAIL wd_clear: got %b want 0", stall_timeout);
      end
   endtask

`ifdef STALL_PERF_EN
   task automatic test_perf();
      logic [31:0] exp_t [8] = '{32'd0, 32'd4, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      do_reset();
      set_req(4'b0100);
      for (int i = 0; i < 4; i++) step();
      set_req(4'b0011);
      for (int i = 0; i < 2; i++) step();
      set_req(4'b0000);
      for (int s = 0; s < 8; s++) begin
         perf_sel = 3'(s);
         #1;
         n_cmp++;
         if (perf_data !== exp_t[s]) begin
            n_err++; $display("FAIL perf_sel%0d: got %0d want %0d", s, perf_data, exp_t[s]);
         end
      end
   endtask
`endif

   initial begin
`ifdef STALL_PERF_EN
      perf_sel = 3'd0;
`endif
      test_reset();
      test_priority();
      test_branch_idle();
      test_branch_pend();
      test_back_to_back();
      test_rst_pend();
      test_watchdog();
`ifdef STALL_PERF_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline control unit for the five-stage RISC-V core; it produces the `stall` vector consumed by every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb) and the branch flush/redirect. It prioritises stall requests from the stages, holds a taken-branch redirect until the PC stage can accept it, and runs a stall watchdog. Optional performance counters record stall cycles per cause.

## Interface
- `STALL_LIMIT`, 1024: consecutive PC-stall cycles that trip the watchdog (≥2).
- `CNT_W`, 32: performance counter width.
- `clk  in  1  clock`
- `rst  in  1  synchronous, active-high reset`
- `stallreq_if  in  1  fetch waiting on instruction memory`
- `stallreq_id  in  1  load-use hazard in decode`
- `stallreq_ex  in  1  multi-cycle EX operation busy`
- `stallreq_mem  in  1  data memory access busy`
- `branch_i  in  1  EX resolved a taken branch/jump (single-cycle pulse)`
- `branch_target_i  in  32  redirect address`
- `stall  out  6  [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb; 1=Stop`
- `flush  out  1  kill if_id and id_ex contents`
- `redirect_valid  out  1  pc loads redirect_pc this cycle`
- `redirect_pc  out  32  redirect address`
- `stall_timeout  out  1  sticky watchdog flag`
- `perf_sel  in  3  counter select (STALL_PERF_EN only)`
- `perf_data  out  CNT_W  selected counter (STALL_PERF_EN only)`

## Operation
- `stall` combinational from requests, fixed priority: mem → 6'b011111; else ex → 6'b001111; else id → 6'b000111; else if → 6'b000011; else 6'b000000. Wb never stalls.
- Each pipeline register inserts a bubble when stall[k]=1 and stall[k+1]=0; this block guarantees the vector is always a contiguous run of ones from bit 0.
- Redirect FSM, states IDLE and PEND:
  - IDLE, branch_i=1, stall[0]=0: flush=1, redirect_valid=1, redirect_pc=branch_target_i, same cycle; stay IDLE.
  - IDLE, branch_i=1, stall[0]=1: latch target into pend_pc; go PEND; flush=1 immediately (younger instructions are killed regardless of stall).
  - PEND, stall[0]=0: redirect_valid=1, redirect_pc=pend_pc, flush=1; go IDLE.
  - PEND, stall[0]=1: hold; flush=1 every cycle so refilled slots stay empty.
  - PEND, branch_i=1: pend_pc overwritten (latest wins); released per the rules above.
- redirect_pc=0 when redirect_valid=0.
- Watchdog: counter increments each cycle stall[0]=1 and clears when stall[0]=0; when it reaches STALL_LIMIT, stall_timeout sets and stays set until rst; the counter saturates.

## Timing
- stall, flush, redirect_*: zero-cycle combinational from inputs and the FSM state.
- The PEND transition and pend_pc capture take effect on the clk edge after branch_i.
- Reset values: state IDLE, pend_pc=0, watchdog=0, stall_timeout=0, perf counters=0. stall is combinational, so it follows the inputs during rst. flush=0 and redirect_valid=0 while rst=1.
- rst mid-PEND discards the pending redirect; no redirect_valid is issued.
- stall_timeout rises on the edge where the count reaches STALL_LIMIT, i.e. visible STALL_LIMIT cycles after the first stalled cycle.

## Configuration
- `STALL_PERF_EN` defined: five CNT_W wrapping counters, each incremented once per cycle. Selection is by perf_sel: 0=mem-cause, 1=ex-cause, 2=id-cause, 3=if-cause (the winning priority source only), 4=flush cycles. perf_sel 5–7 reads 0. perf_data is combinational from the counters.
- Not defined: counters, perf_sel and perf_data are absent from the port list. No other behaviour changes.

## Test plan
- stallreq_id=1 and stallreq_if=1 together → stall=6'b000111; add stallreq_mem=1 → 6'b011111.
- branch_i=1, target 0x0000_0100, no stalls → same cycle: flush=1, redirect_valid=1, redirect_pc=0x100; next cycle both 0.
- stallreq_if held for 3 cycles; branch_i pulse in the first cycle with target 0x200 → flush=1 for 3 cycles, redirect_valid=0. In the first unstalled cycle: redirect_valid=1, redirect_pc=0x200.
- In PEND, second branch_i with target 0x300 → released redirect_pc=0x300, single redirect_valid pulse.
- STALL_LIMIT=8, stallreq_mem held for 8 cycles → stall_timeout=1 after the 8th edge and still 1 after the stall clears. rst → 0.
- With STALL_PERF_EN: 4 cycles stallreq_ex then 2 cycles stallreq_if+stallreq_id → perf_sel=1 reads 4, perf_sel=2 reads 2, perf_sel=3 reads 0.
